// File: rtl/drive_pkg.sv
// drive_pkg: ramp sequencer state encoding and default widths shared with the half-bridge driver
package drive_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    HOLD      = 3'd2,
    RAMP_DOWN = 3'd3,
    FAULT     = 3'd4
  } ramp_state_t;
  localparam int FREQ_W     = 19;
  localparam int DUTY_W     = 7;
  localparam int PHASE_W    = 9;
  localparam int DEADTIME_W = 8;
  localparam int TICK_W     = 24;
  localparam int FINC_W     = 16;
endpackage

// File: rtl/slew_step.sv
// slew_step: one saturating step of cur toward tgt by at most inc (inc of 0 acts as 1)
module slew_step #(
  parameter int W     = 8,
  parameter int INC_W = 8
) (
  input  logic [W-1:0]     cur,
  input  logic [W-1:0]     tgt,
  input  logic [INC_W-1:0] inc,
  output logic [W-1:0]     next,
  output logic             reached
);
  localparam int MW = (W > INC_W ? W : INC_W) + 1;
  logic [MW-1:0] c, t, d, s, m;
  always_comb begin
    c = MW'(cur);
    t = MW'(tgt);
    d = t > c ? t - c : c - t;
    s = inc == '0 ? MW'(1) : MW'(inc);
    m = s < d ? s : d;
    next = W'(t > c ? c + m : c - m);
    reached = next == tgt;
  end
endmodule

// File: rtl/drive_ramp_ctrl.sv
// drive_ramp_ctrl: soft-start/soft-stop sequencer slewing freq/duty/phase into the half-bridge driver
module drive_ramp_ctrl
  import drive_pkg::*;
#(
  parameter int FREQ_BITS     = FREQ_W,
  parameter int DUTY_BITS     = DUTY_W,
  parameter int PHASE_BITS    = PHASE_W,
  parameter int DEADTIME_BITS = DEADTIME_W,
  parameter int TICK_BITS     = TICK_W,
  parameter int FINC_BITS     = FINC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     update,
  input  logic                     fault,
  input  logic                     fault_clr,
  input  logic [FREQ_BITS-1:0]     tgt_freq,
  input  logic [DUTY_BITS-1:0]     tgt_duty,
  input  logic [PHASE_BITS-1:0]    tgt_phase,
  input  logic [FREQ_BITS-1:0]     start_freq,
  input  logic [FINC_BITS-1:0]     freq_inc,
  input  logic [TICK_BITS-1:0]     tick_div,
  input  logic [DEADTIME_BITS-1:0] deadtime_in,
  output logic [FREQ_BITS-1:0]     freq,
  output logic [DUTY_BITS-1:0]     duty,
  output logic [PHASE_BITS-1:0]    phase,
  output logic [DEADTIME_BITS-1:0] deadtime,
  output logic                     drv_en,
  output logic                     busy,
  output logic                     at_target,
  output logic                     fault_latched,
  output logic [2:0]               state
);
  ramp_state_t st, st_n;
  logic [FREQ_BITS-1:0] freq_n, lt_freq, lt_freq_n, f_step;
  logic [DUTY_BITS-1:0] duty_n, lt_duty, lt_duty_n, d_step;
  logic [PHASE_BITS-1:0] phase_n, lt_phase, lt_phase_n, p_step;
  logic [TICK_BITS-1:0] cnt, cnt_n;
  logic drv_en_n, at_target_n, fault_latched_n, f_hit, d_hit, p_hit, ramping, step;
  slew_step #(.W(FREQ_BITS), .INC_W(FINC_BITS)) u_freq (
    .cur(freq), .tgt(lt_freq), .inc(freq_inc), .next(f_step), .reached(f_hit)
  );
  slew_step #(.W(DUTY_BITS), .INC_W(1)) u_duty (
    .cur(duty), .tgt(lt_duty), .inc(1'b1), .next(d_step), .reached(d_hit)
  );
  slew_step #(.W(PHASE_BITS), .INC_W(1)) u_phase (
    .cur(phase), .tgt(lt_phase), .inc(1'b1), .next(p_step), .reached(p_hit)
  );
  assign ramping = st == RAMP_UP || st == RAMP_DOWN;
  assign step = ramping && cnt == tick_div;
  assign busy = st != IDLE;
  assign state = st;
  always_comb begin
    st_n = st;
    freq_n = freq;
    duty_n = duty;
    phase_n = phase;
    drv_en_n = drv_en;
    at_target_n = at_target;
    fault_latched_n = fault_latched;
    lt_freq_n = lt_freq;
    lt_duty_n = lt_duty;
    lt_phase_n = lt_phase;
    cnt_n = (step || !ramping) ? '0 : cnt + 1'b1;
    if (fault) begin
      st_n = FAULT;
      duty_n = '0;
      drv_en_n = 1'b0;
      at_target_n = 1'b0;
      fault_latched_n = 1'b1;
    end else if (st == FAULT) begin
      if (fault_clr) begin
        st_n = IDLE;
        fault_latched_n = 1'b0;
      end
    end else if (st == IDLE) begin
      if (start) begin
        st_n = RAMP_UP;
        lt_freq_n = tgt_freq;
        lt_duty_n = tgt_duty;
        lt_phase_n = tgt_phase;
        freq_n = start_freq;
        duty_n = '0;
        phase_n = '0;
        drv_en_n = 1'b1;
        cnt_n = '0;
      end
    end else if (st == RAMP_DOWN) begin
      if (step) begin
        duty_n = duty - DUTY_BITS'(duty != '0);
        st_n = duty <= DUTY_BITS'(1) ? IDLE : RAMP_DOWN;
        drv_en_n = duty > DUTY_BITS'(1);
      end
    end else if (stop) begin
      st_n = RAMP_DOWN;
      at_target_n = 1'b0;
      cnt_n = '0;
    end else if (update) begin
      // retarget slews from the present outputs, never back to start_freq
      st_n = RAMP_UP;
      lt_freq_n = tgt_freq;
      lt_duty_n = tgt_duty;
      lt_phase_n = tgt_phase;
      at_target_n = 1'b0;
      cnt_n = '0;
    end else if (st == RAMP_UP && step) begin
      freq_n = f_step;
      duty_n = d_step;
      phase_n = p_step;
      if (f_hit && d_hit && p_hit) begin
        st_n = HOLD;
        at_target_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      freq <= '0;
      duty <= '0;
      phase <= '0;
      deadtime <= '0;
      drv_en <= 1'b0;
      at_target <= 1'b0;
      fault_latched <= 1'b0;
      lt_freq <= '0;
      lt_duty <= '0;
      lt_phase <= '0;
      cnt <= '0;
    end else begin
      st <= st_n;
      freq <= freq_n;
      duty <= duty_n;
      phase <= phase_n;
      deadtime <= deadtime_in;
      drv_en <= drv_en_n;
      at_target <= at_target_n;
      fault_latched <= fault_latched_n;
      lt_freq <= lt_freq_n;
      lt_duty <= lt_duty_n;
      lt_phase <= lt_phase_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: doc/drive_ramp_ctrl.md
Name: drive_ramp_ctrl

Overview:
- Soft-start/soft-stop sequencer that feeds the freq/duty/phase/deadtime inputs of the fixed-parameter half-bridge driver.
- On start, it enables the driver at a safe start frequency and zero duty. It then slews frequency, duty and phase toward latched targets, one step per programmable tick.
- On stop, it ramps duty down to zero before disabling.
- A fault input kills the output immediately.
- Sits between the register/host interface and the driver.

Parameters:
FREQ_BITS, 19, width of frequency code (driver freq input)
DUTY_BITS, 7, width of duty code (0..100 scale)
PHASE_BITS, 9, width of phase code (0..359 scale)
DEADTIME_BITS, 8, width of deadtime code
TICK_BITS, 24, width of step-interval divider
FINC_BITS, 16, width of per-step frequency increment

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
start  in  1  pulse: begin ramp-up from IDLE
stop  in  1  pulse: begin ramp-down
update  in  1  pulse: re-latch targets while running
fault  in  1  level: hard abort
fault_clr  in  1  pulse: leave FAULT
tgt_freq  in  FREQ_BITS  target frequency code
tgt_duty  in  DUTY_BITS  target duty code
tgt_phase  in  PHASE_BITS  target phase code
start_freq  in  FREQ_BITS  frequency applied at enable
freq_inc  in  FINC_BITS  max frequency change per step
tick_div  in  TICK_BITS  step interval minus one, in clk cycles
deadtime_in  in  DEADTIME_BITS  deadtime passed through (registered)
freq  out  FREQ_BITS  to driver
duty  out  DUTY_BITS  to driver
phase  out  PHASE_BITS  to driver
deadtime  out  DEADTIME_BITS  to driver
drv_en  out  1  driver enable
busy  out  1  state != IDLE
at_target  out  1  in HOLD
fault_latched  out  1  in FAULT
state  out  3  current state code (debug)

Behaviour:
- Reset (rst low, async): all outputs 0; state=IDLE; tick counter=0; latched targets=0.
- States: IDLE, RAMP_UP, HOLD, RAMP_DOWN, FAULT.
- Event priority within one cycle: fault > stop > update > start.
- IDLE:
  - drv_en=0; duty=0.
  - On start: latch tgt_*; freq<=start_freq; duty<=0; phase<=0; drv_en<=1; tick counter cleared; go to RAMP_UP. drv_en is high the cycle after start.
- Tick:
  - Counter runs in RAMP_UP/RAMP_DOWN and counts 0..tick_div.
  - A step fires on the cycle the counter equals tick_div; the counter then wraps to 0.
  - tick_div=0 gives a step every cycle. The first step occurs tick_div+1 cycles after entry.
- RAMP_UP step:
  - freq moves toward latched target by min(freq_inc, |diff|), up or down. Freq arithmetic is FREQ_BITS+1 wide, with no overflow or underflow.
  - freq_inc=0 is treated as 1.
  - duty and phase each move by 1 toward their targets.
  - When all three equal their targets after a step: go to HOLD and set at_target=1 the same edge.
  - If targets already equal the start values: go to HOLD on the first step.
- HOLD:
  - Outputs constant.
  - On update: re-latch targets, clear at_target, go to RAMP_UP. Slewing starts from the current outputs; there is no reset to start_freq.
- stop in RAMP_UP or HOLD:
  - Go to RAMP_DOWN; clear at_target.
  - freq and phase are frozen; duty decrements by 1 per step.
  - When duty==0 is reached by a step: drv_en<=0, go to IDLE. freq/phase hold their last values.
  - stop or update during RAMP_DOWN is ignored. start while busy is ignored.
- Fault:
  - fault high in any state: next edge sets duty<=0, drv_en<=0, fault_latched<=1, state=FAULT.
  - FAULT is left only on fault_clr with fault low → IDLE. fault_clr with fault still high is ignored.
- deadtime is registered from deadtime_in every cycle, independent of state.
- Outputs are registers only; there are no combinational paths from inputs to outputs.

Decomposition:
- drive_pkg holds:
  - the ramp_state_t enum (IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3, FAULT=4);
  - default width localparams shared with the driver.
- Sub-module slew_step #(W, INC_W): combinational saturating step of cur toward tgt by inc. Outputs next and reached. Instantiated three times: freq with freq_inc; duty and phase with inc=1.

Test Plan:
- Ramp-up: start_freq=1000, tgt_freq=1010, freq_inc=4, tgt_duty=3, tgt_phase=2, tick_div=9, start pulse. Steps occur 10 cycles apart. freq sequence is 1004, 1008, 1010; duty is 1, 2, 3; phase is 1, 2, 2. HOLD and at_target=1 on the 3rd step edge (31 cycles after start).
- Downward frequency plus retarget: in HOLD at 1010, update with tgt_freq=1001, freq_inc=4. freq sequence is 1006, 1002, 1001; at_target drops on update and rises again on reaching 1001.
- Soft stop: HOLD with duty=3, tick_div=0, stop. duty sequence is 2, 1, 0 on consecutive cycles; drv_en=0 and state=IDLE on the edge where duty reaches 0; freq is unchanged.
- Fault mid-ramp: fault asserted during RAMP_UP. Next edge gives duty=0, drv_en=0, fault_latched=1. fault_clr while fault is high leaves state unchanged. fault low plus fault_clr gives IDLE.
- Priority and corners:
  - start, stop and fault in the same cycle from IDLE → FAULT.
  - freq_inc=0 → freq steps by 1.
  - start during HOLD → ignored.
- Async reset mid-RAMP_UP: rst low between edges → all outputs 0 immediately, before the next clock edge; after release, state=IDLE.
